icache: RTL

Direct-mapped instruction cache between the IF stage and `mem_ctrl`. It answers IF fetches from on-chip storage on a hit. On a miss it requests the instruction word from `mem_ctrl` over the `icache_needed` / `icache_addr` / `inst_available_o` / `inst_icache` interface. It fills the line, forwards the word to IF, and abandons an outstanding miss on `jump_signal`.

---
 rtl/icache.sv | 104 ++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache sitting between IF and mem_ctrl.
// Hits answer combinationally; misses fetch one word from mem_ctrl and forward it on arrival.
module icache #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_LEN   = 32,
    parameter int INST_LEN   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                jump_signal,
    input  logic                if_req,
    input  logic [ADDR_LEN-1:0] if_addr,
    output logic                inst_valid_o,
    output logic [INST_LEN-1:0] inst_o,
    output logic                icache_needed,
    output logic [ADDR_LEN-1:0] icache_addr,
    input  logic                inst_available_o,
    input  logic [INST_LEN-1:0] inst_icache
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_LEN - INDEX_BITS - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state, state_next;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [INST_LEN-1:0]   data_mem [LINES];
    logic [ADDR_LEN-1:0]   miss_addr;

    logic [INDEX_BITS-1:0] req_index, fill_index;
    logic [TAG_BITS-1:0]   req_tag, fill_tag;
    logic                  hit, latch_miss, fill_we;

    assign req_index  = if_addr[INDEX_BITS+1:2];
    assign req_tag    = if_addr[ADDR_LEN-1:INDEX_BITS+2];
    assign fill_index = miss_addr[INDEX_BITS+1:2];
    assign fill_tag   = miss_addr[ADDR_LEN-1:INDEX_BITS+2];
    assign hit        = if_req && (state == IDLE) && valid[req_index]
                        && (tag_mem[req_index] == req_tag);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_next    = state;
        inst_valid_o  = 1'b0;
        inst_o        = '0;
        icache_needed = 1'b0;
        icache_addr   = '0;
        latch_miss    = 1'b0;
        fill_we       = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    inst_valid_o = 1'b1;
                    inst_o       = data_mem[req_index];
                end else if (if_req && !jump_signal) begin
                    latch_miss = 1'b1;
                    state_next = MISS;
                end
            end
            MISS: begin
                icache_addr   = miss_addr;
                icache_needed = !inst_available_o && !jump_signal;
                if (inst_available_o) begin
                    // A fill racing a jump is still written: the word belongs to miss_addr.
                    fill_we    = 1'b1;
                    state_next = IDLE;
                    if (!jump_signal) begin
                        inst_valid_o = 1'b1;
                        inst_o       = inst_icache;
                    end
                end else if (jump_signal) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_next;
            if (latch_miss)
                miss_addr <= {if_addr[ADDR_LEN-1:2], 2'b00};
            if (fill_we)
                valid[fill_index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; valid bits alone make stale contents harmless.
    always_ff @(posedge clk) begin
        if (fill_we && !rst) begin
            tag_mem[fill_index]  <= fill_tag;
            data_mem[fill_index] <= inst_icache;
        end
    end

endmodule
